// File: rtl/tcm_axi_loader.sv
// Streams a block of 32-bit words into TCM through an AXI write burst master.
// Define TCM_LOADER_CHKSUM_EN to add the checksum_o additive checksum port.
module tcm_axi_loader #(
  parameter int BURST_LEN = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [31:0] base_addr_i,
  input  logic [15:0] word_count_i,
  input  logic        in_valid_i,
  input  logic [31:0] in_data_i,
  output logic        in_ready_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
`ifdef TCM_LOADER_CHKSUM_EN
  output logic [31:0] checksum_o,
`endif
  output logic        awvalid_o,
  output logic [31:0] awaddr_o,
  output logic [3:0]  awid_o,
  output logic [7:0]  awlen_o,
  output logic [1:0]  awburst_o,
  input  logic        awready_i,
  output logic        wvalid_o,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic        wlast_o,
  input  logic        wready_i,
  input  logic        bvalid_i,
  input  logic [1:0]  bresp_i,
  input  logic [3:0]  bid_i,
  output logic        bready_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_RESP
  } state_t;

  localparam logic [16:0] LP_BURST = 17'(BURST_LEN);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_addr;
  logic [15:0] r_remaining;
  logic [8:0]  r_beats;
  logic [7:0]  r_awlen;
  logic [7:0]  r_beat_cnt;
  logic        r_done;
  logic        r_error;

  logic        w_start_ok;
  logic        w_whs;
  logic        w_bhs;
  logic        w_load_burst;
  logic        w_awvalid;
  logic        w_wvalid;
  logic        w_in_ready;
  logic        w_wlast;
  logic        w_bready;
  logic [31:0] w_addr_upd;
  logic [15:0] w_rem_upd;
  logic [31:0] w_burst_addr;
  logic [15:0] w_burst_rem;
  logic [8:0]  w_burst_beats;
  logic        w_unused;

  // Beats = min(remaining, BURST_LEN, words left before the next 4KB boundary).
  function automatic logic [8:0] f_beats(input logic [9:0] word_off, input logic [15:0] rem);
    logic [16:0] lim;
    logic [16:0] to_bound;
    to_bound = 17'd1024 - {7'd0, word_off};
    lim      = {1'b0, rem};
    if (LP_BURST < lim) lim = LP_BURST;
    if (to_bound < lim) lim = to_bound;
    return lim[8:0];
  endfunction

  assign w_start_ok = (r_state == S_IDLE) && start_i;
  assign w_whs      = (r_state == S_DATA) && in_valid_i && wready_i;
  assign w_bhs      = (r_state == S_RESP) && bvalid_i;

  assign w_addr_upd    = r_addr + {21'd0, r_beats, 2'b00};
  assign w_rem_upd     = r_remaining - {7'd0, r_beats};
  assign w_burst_addr  = (r_state == S_IDLE) ? base_addr_i  : w_addr_upd;
  assign w_burst_rem   = (r_state == S_IDLE) ? word_count_i : w_rem_upd;
  assign w_burst_beats = f_beats(w_burst_addr[11:2], w_burst_rem);

  always_comb begin
    w_state_nxt  = r_state;
    w_load_burst = 1'b0;
    w_awvalid    = 1'b0;
    w_wvalid     = 1'b0;
    w_in_ready   = 1'b0;
    w_wlast      = 1'b0;
    w_bready     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start_i && (word_count_i != 16'd0)) begin
          w_state_nxt  = S_ADDR;
          w_load_burst = 1'b1;
        end
      end
      S_ADDR: begin
        w_awvalid = 1'b1;
        if (awready_i) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        w_wvalid   = in_valid_i;
        w_in_ready = wready_i;
        w_wlast    = (r_beat_cnt == r_awlen);
        if (w_whs && w_wlast) w_state_nxt = S_RESP;
      end
      S_RESP: begin
        w_bready = 1'b1;
        if (bvalid_i) begin
          if (w_rem_upd == 16'd0) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt  = S_ADDR;
            w_load_burst = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_addr      <= 32'd0;
      r_remaining <= 16'd0;
      r_beats     <= 9'd0;
      r_awlen     <= 8'd0;
      r_beat_cnt  <= 8'd0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= 1'b0;
      if (w_start_ok) begin
        r_error <= 1'b0;
        if (word_count_i == 16'd0) r_done <= 1'b1;
      end
      if (w_whs) begin
        r_beat_cnt <= w_wlast ? 8'd0 : r_beat_cnt + 8'd1;
      end
      if (w_bhs) begin
        r_addr      <= w_addr_upd;
        r_remaining <= w_rem_upd;
        if (bresp_i != 2'b00) r_error <= 1'b1;
        if (w_rem_upd == 16'd0) r_done <= 1'b1;
      end
      // A new burst is sized from the up-to-date address and remaining count.
      if (w_load_burst) begin
        r_addr      <= w_burst_addr;
        r_remaining <= w_burst_rem;
        r_beats     <= w_burst_beats;
        r_awlen     <= 8'(w_burst_beats - 9'd1);
        r_beat_cnt  <= 8'd0;
      end
    end
  end

`ifdef TCM_LOADER_CHKSUM_EN
  logic [31:0] r_checksum;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_checksum <= 32'd0;
    end else if (w_start_ok) begin
      r_checksum <= 32'd0;
    end else if (w_whs) begin
      r_checksum <= r_checksum + in_data_i;
    end
  end

  assign checksum_o = r_checksum;
`endif

  assign w_unused = ^bid_i;

  assign busy_o     = (r_state != S_IDLE);
  assign done_o     = r_done;
  assign error_o    = r_error;
  assign in_ready_o = w_in_ready;
  assign awvalid_o  = w_awvalid;
  assign awaddr_o   = r_addr;
  assign awid_o     = 4'd0;
  assign awlen_o    = r_awlen;
  assign awburst_o  = 2'b01;
  assign wvalid_o   = w_wvalid;
  assign wdata_o    = in_data_i;
  assign wstrb_o    = 4'hF;
  assign wlast_o    = w_wlast;
  assign bready_o   = w_bready;

endmodule
